// File: rtl/host_io_bridge.sv
// Byte-wide host I/O bridge: assembles inbound host byte pairs into 16-bit CPU words
// and streams changed CPU output words back to the host as two bytes under valid/ack.
module host_io_bridge #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  host_byte,
  input  logic        host_strobe,
  input  logic        host_ack,
  input  logic [15:0] cpu_data_out,
  output logic [15:0] cpu_data_in,
  output logic        cpu_data_read,
  output logic [7:0]  host_out,
  output logic        host_out_valid,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2
  } tx_state_e;

  logic [2:0]    r_stb_sync;
  logic [2:0]    r_ack_sync;
  logic          w_stb_edge;
  logic          w_ack_edge;

  logic          r_rx_phase;
  logic [7:0]    r_rx_lo;

  logic [15:0]   r_last_out;
  logic          w_change;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_rd_data;

  tx_state_e     r_state;
  logic [7:0]    r_tx_hi;

  // Two-flop synchronisers plus a third flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_sync <= 3'b000;
      r_ack_sync <= 3'b000;
    end else begin
      r_stb_sync <= {r_stb_sync[1:0], host_strobe};
      r_ack_sync <= {r_ack_sync[1:0], host_ack};
    end
  end

  assign w_stb_edge = r_stb_sync[1] & ~r_stb_sync[2];
  assign w_ack_edge = r_ack_sync[1] & ~r_ack_sync[2];

  // Inbound assembly, low byte first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_phase    <= 1'b0;
      r_rx_lo       <= 8'h00;
      cpu_data_in   <= 16'h0000;
      cpu_data_read <= 1'b0;
    end else begin
      cpu_data_read <= 1'b0;
      if (w_stb_edge) begin
        if (!r_rx_phase) begin
          r_rx_lo    <= host_byte;
          r_rx_phase <= 1'b1;
        end else begin
          cpu_data_in   <= {host_byte, r_rx_lo};
          cpu_data_read <= 1'b1;
          r_rx_phase    <= 1'b0;
        end
      end
    end
  end

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_change  = (cpu_data_out != r_last_out);
  assign w_pop     = ~w_empty & ((r_state == TX_IDLE) | ((r_state == TX_HI) & w_ack_edge));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word
  assign w_push    = w_change & (~w_full | w_pop);
  assign w_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_out <= 16'h0000;
      overflow   <= 1'b0;
    end else if (w_change) begin
      r_last_out <= cpu_data_out;
      if (!w_push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cpu_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outbound byte sequencer; chains straight into the next word without an idle bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= TX_IDLE;
      r_tx_hi        <= 8'h00;
      host_out       <= 8'h00;
      host_out_valid <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (!w_empty) begin
            host_out       <= w_rd_data[7:0];
            r_tx_hi        <= w_rd_data[15:8];
            host_out_valid <= 1'b1;
            r_state        <= TX_LO;
          end
        end
        TX_LO: begin
          if (w_ack_edge) begin
            host_out <= r_tx_hi;
            r_state  <= TX_HI;
          end
        end
        TX_HI: begin
          if (w_ack_edge) begin
            if (!w_empty) begin
              host_out <= w_rd_data[7:0];
              r_tx_hi  <= w_rd_data[15:8];
              r_state  <= TX_LO;
            end else begin
              host_out_valid <= 1'b0;
              r_state        <= TX_IDLE;
            end
          end
        end
        default: begin
          host_out_valid <= 1'b0;
          r_state        <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
